regfile_scoreboard: RTL and testbench

Parametrised multi-entry register file with two combinational read ports and one synchronous write port. Adds an asynchronous clear of all registers and a per-register pending scoreboard. The scoreboard lets an issue stage reserve a destination and stall readers until the result is written back. It sits between the decode/issue stage and the ALU writeback path.

---
 rtl/regfile_scoreboard.sv | 128 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Multi-entry register file with two combinational read ports, one synchronous
//   write port, an asynchronous clear of all state, and a per-register pending
//   scoreboard. The issue stage reserves a destination (rsv_*), which marks it
//   pending until writeback (wr_*) commits a value. Readers see rd_rdyN = 0 while
//   the register they address is pending.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined     - a read port addressing the register being written this cycle
//                   returns wr_data combinationally with rd_rdyN = 1.
//     not defined - reads return stored contents only.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   src1/src2             read indices
//   rd_data1/rd_data2     register contents
//   rd_rdy1/rd_rdy2       addressed register is not pending
//   rsv_valid/rsv_dst     reservation request and target
//   rsv_ready             reservation can be accepted this cycle
//   wr_en/wr_dst/wr_data  writeback strobe, index and data
//   wr_err                one-cycle flag: last write hit a non-pending register
//   pend_count            number of registers currently pending
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 2,
    parameter bit          HAS_ZERO = 1'b1,
    parameter int unsigned ZERO_IDX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_rdy1,
    output logic              rd_rdy2,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_dst,
    output logic              rsv_ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_dst,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    output logic [ADDR_W:0]   pend_count
);

    localparam int unsigned       DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZIDX  = ADDR_W'(ZERO_IDX);

    function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
        return HAS_ZERO && (idx == ZIDX);
    endfunction

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic              wr_err_q;
    logic [ADDR_W:0]   pend_count_q;
    logic [ADDR_W:0]   pend_count_d;
    logic              wr_live;
    logic              rsv_accept;

    // Writes to the hardwired-zero register are dropped entirely.
    assign wr_live = wr_en & ~is_zero(wr_dst);

    always_comb begin
        rd_data1 = is_zero(src1) ? '0 : regs_q[src1];
        rd_rdy1  = is_zero(src1) | ~pend_q[src1];
        rd_data2 = is_zero(src2) ? '0 : regs_q[src2];
        rd_rdy2  = is_zero(src2) | ~pend_q[src2];
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (src1 == wr_dst)) begin
            rd_data1 = wr_data;
            rd_rdy1  = 1'b1;
        end
        if (wr_live && (src2 == wr_dst)) begin
            rd_data2 = wr_data;
            rd_rdy2  = 1'b1;
        end
`endif
    end

    // A writeback to the same index frees the slot in the same cycle.
    assign rsv_ready  = is_zero(rsv_dst) | ~pend_q[rsv_dst] |
                        (wr_en & (wr_dst == rsv_dst));
    assign rsv_accept = rsv_valid & rsv_ready;

    // Clear from writeback first, then set from reservation, so a same-index
    // write + accepted reservation leaves the register pending.
    always_comb begin
        pend_d = pend_q;
        if (wr_live) begin
            pend_d[wr_dst] = 1'b0;
        end
        if (rsv_accept && !is_zero(rsv_dst)) begin
            pend_d[rsv_dst] = 1'b1;
        end
    end

    always_comb begin
        pend_count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pend_count_d = pend_count_d + (ADDR_W + 1)'(pend_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q       <= '0;
            wr_err_q     <= 1'b0;
            pend_count_q <= '0;
        end else begin
            if (wr_live) begin
                regs_q[wr_dst] <= wr_data;
            end
            pend_q       <= pend_d;
            wr_err_q     <= wr_live & ~pend_q[wr_dst];
            pend_count_q <= pend_count_d;
        end
    end

    assign wr_err     = wr_err_q;
    assign pend_count = pend_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (default parameters: 4 x 8-bit,
// register 3 hardwired to zero). Combinational outputs are compared while the
// inputs are held; expected registered outputs are queued when a cycle's
// stimulus is driven and compared after the following clock edge.
module tb_regfile_scoreboard;

    logic       clk;
    logic       rst_n;
    logic [1:0] src1, src2;
    logic [7:0] rd_data1, rd_data2;
    logic       rd_rdy1, rd_rdy2;
    logic       rsv_valid;
    logic [1:0] rsv_dst;
    logic       rsv_ready;
    logic       wr_en;
    logic [1:0] wr_dst;
    logic [7:0] wr_data;
    logic       wr_err;
    logic [2:0] pend_count;

    regfile_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src1       (src1),
        .src2       (src2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .rd_rdy1    (rd_rdy1),
        .rd_rdy2    (rd_rdy2),
        .rsv_valid  (rsv_valid),
        .rsv_dst    (rsv_dst),
        .rsv_ready  (rsv_ready),
        .wr_en      (wr_en),
        .wr_dst     (wr_dst),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .pend_count (pend_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [2:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    // Reference state
    logic [7:0] m_regs [4];
    logic       m_pend [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_zero(input logic [1:0] idx);
        return idx == 2'd3;
    endfunction

    function automatic logic [7:0] m_rd(input logic [1:0] s);
        if (m_zero(s)) return 8'h00;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_dst == s) return wr_data;
`endif
        return m_regs[s];
    endfunction

    function automatic logic m_rdy(input logic [1:0] s);
        if (m_zero(s)) return 1'b1;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_dst == s) return 1'b1;
`endif
        return !m_pend[s];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_regs[i] = 8'h00;
            m_pend[i] = 1'b0;
        end
        sb_q.delete();
    endtask

    // Drive one cycle of stimulus, compare combinational outputs, advance the
    // model and queue the registered outputs expected after the next edge.
    task automatic set_inputs(input logic rv, input logic [1:0] rd, input logic we,
                              input logic [1:0] wd, input logic [7:0] wdat,
                              input logic [1:0] s1, input logic [1:0] s2);
        logic ready;
        exp_t e;
        int   cnt;
        rsv_valid = rv;
        rsv_dst   = rd;
        wr_en     = we;
        wr_dst    = wd;
        wr_data   = wdat;
        src1      = s1;
        src2      = s2;
        #1;
        ready = m_zero(rd) || !m_pend[rd] || (we && wd == rd);
        check("rd_data1", rd_data1, m_rd(s1));
        check("rd_data2", rd_data2, m_rd(s2));
        check("rd_rdy1", rd_rdy1, m_rdy(s1));
        check("rd_rdy2", rd_rdy2, m_rdy(s2));
        check("rsv_ready", rsv_ready, ready);
        e.err = we && !m_pend[wd] && !m_zero(wd);
        if (we && !m_zero(wd)) begin
            m_regs[wd] = wdat;
            m_pend[wd] = 1'b0;
        end
        if (rv && ready && !m_zero(rd)) m_pend[rd] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) cnt += int'(m_pend[i]);
        e.cnt = 3'(cnt);
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("wr_err", wr_err, e.err);
            check("pend_count", pend_count, e.cnt);
        end
    endtask

    task automatic idle(input logic [1:0] s1, input logic [1:0] s2);
        set_inputs(1'b0, 2'd0, 1'b0, 2'd0, 8'h00, s1, s2);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        rsv_valid = 1'b0; rsv_dst = 2'd0; wr_en = 1'b0; wr_dst = 2'd0;
        wr_data = 8'h00; src1 = 2'd0; src2 = 2'd0;
        m_reset();
        #12;
        check("rst_pend_count", pend_count, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_rd_data1", rd_data1, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write reg0 then clear it with a mid-cycle asynchronous reset
        set_inputs(1'b0, 2'd0, 1'b1, 2'd0, 8'h5A, 2'd0, 2'd1);
        tick();
        idle(2'd0, 2'd1);
        check("reg0_written", rd_data1, 8'h5A);
        #2 rst_n = 1'b0;
        #1;
        check("async_clr_data", rd_data1, 8'h00);
        check("async_clr_count", pend_count, 0);
        check("async_clr_err", wr_err, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reserve reg1, then try again while pending
        set_inputs(1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 2'd1, 2'd2);
        tick();
        check("rsv_rdy1", rd_rdy1, 0);
        check("rsv_count", pend_count, 1);
        set_inputs(1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 2'd1, 2'd2);
        check("rsv_blocked", rsv_ready, 0);
        tick();
        check("rsv_count_hold", pend_count, 1);

        // Writeback to pending reg1
        set_inputs(1'b0, 2'd0, 1'b1, 2'd1, 8'hC3, 2'd1, 2'd2);
        tick();
        check("wb_data", rd_data1, 8'hC3);
        check("wb_rdy", rd_rdy1, 1);
        check("wb_count", pend_count, 0);
        check("wb_err", wr_err, 0);

        // Write to non-pending reg2: one-cycle error flag
        set_inputs(1'b0, 2'd0, 1'b1, 2'd2, 8'h11, 2'd1, 2'd2);
        tick();
        check("err_set", wr_err, 1);
        idle(2'd1, 2'd2);
        check("err_clear", wr_err, 0);
        check("reg2_data", rd_data2, 8'h11);

        // Same-edge write + reservation of pending reg1
        set_inputs(1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 2'd1, 2'd2);
        tick();
        set_inputs(1'b1, 2'd1, 1'b1, 2'd1, 8'h22, 2'd1, 2'd2);
        check("same_edge_ready", rsv_ready, 1);
        tick();
        check("same_edge_data", rd_data1, 8'h22);
        check("same_edge_pend", rd_rdy1, 0);
        check("same_edge_count", pend_count, 1);
        set_inputs(1'b0, 2'd0, 1'b1, 2'd1, 8'h33, 2'd1, 2'd2);
        tick();

        // Zero register: write and reserve reg3
        set_inputs(1'b1, 2'd3, 1'b1, 2'd3, 8'hFF, 2'd3, 2'd0);
        check("zero_rsv_ready", rsv_ready, 1);
        tick();
        check("zero_data", rd_data1, 8'h00);
        check("zero_rdy", rd_rdy1, 1);
        check("zero_count", pend_count, 0);
        check("zero_err", wr_err, 0);

        // Same-cycle read of a register being written (reg0 is 0 after reset)
        set_inputs(1'b0, 2'd0, 1'b1, 2'd0, 8'h7E, 2'd0, 2'd3);
`ifdef REGFILE_BYPASS_EN
        check("bypass_data", rd_data1, 8'h7E);
`else
        check("no_bypass_data", rd_data1, 8'h00);
`endif
        tick();
        check("post_write_data", rd_data1, 8'h7E);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            set_inputs(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                       8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
